// File: rtl/draw_player_sprite.sv
// Player sprite overlay: frame-latched position and mirror flag, ROM address
// generation, colour-key transparency, timing bundle delayed to match.
// Latency 3 clocks (pixel_addr 1 clock); no backpressure, one pixel per clock.
module draw_player_sprite #(
  parameter int          IMG_W   = 48,
  parameter int          IMG_H   = 64,
  parameter logic [11:0] KEY_RGB = 12'hF0F
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] xpos,
  input  logic [11:0] ypos,
  input  logic        flip,
  input  logic [10:0] hcount_in,
  input  logic [10:0] vcount_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        hblnk_in,
  input  logic        vblnk_in,
  input  logic [11:0] rgb_in,
  output logic [11:0] pixel_addr,
  input  logic [11:0] rgb_pixel,
  output logic [10:0] hcount_out,
  output logic [10:0] vcount_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        hblnk_out,
  output logic        vblnk_out,
  output logic [11:0] rgb_out
);

  // Timing bundle carried alongside the pixel through the pipeline.
  typedef struct packed {
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;
  } vga_t;

  logic        r_vblnk_prev;
  logic [11:0] r_x_l;
  logic [11:0] r_y_l;
  logic        r_flip_l;

  vga_t        w_in;
  vga_t        r_s1;
  vga_t        r_s2;
  vga_t        r_s3;
  logic        r_inside_d1;
  logic        r_inside_d2;

  logic [11:0] w_dx;
  logic [11:0] w_dy;
  logic [12:0] w_x_end;
  logic [12:0] w_y_end;
  logic        w_inside;
  logic [11:0] w_col;
  logic [11:0] w_rgb_mix;
  logic        w_unused_bits;

  assign w_in = {hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in, rgb_in};

  // Offsets into the sprite; only the low 6 bits reach the ROM.
  assign w_dx = {1'b0, hcount_in} - r_x_l;
  assign w_dy = {1'b0, vcount_in} - r_y_l;

  // End bounds kept 13-bit so a sprite hanging past 2047 clips instead of wrapping.
  assign w_x_end = {1'b0, r_x_l} + 13'(IMG_W);
  assign w_y_end = {1'b0, r_y_l} + 13'(IMG_H);

  assign w_inside = ({1'b0, hcount_in} >= r_x_l) && ({2'b0, hcount_in} < w_x_end) &&
                    ({1'b0, vcount_in} >= r_y_l) && ({2'b0, vcount_in} < w_y_end) &&
                    !hblnk_in && !vblnk_in;

  assign w_col = r_flip_l ? (12'(IMG_W - 1) - w_dx) : w_dx;

  // Key colour in the sprite lets the background show through.
  assign w_rgb_mix = (r_inside_d2 && (rgb_pixel != KEY_RGB)) ? rgb_pixel : r_s2.rgb;

  assign w_unused_bits = &{1'b0, w_dy[11:6], w_col[11:6]};

  // Capture position and flip once per frame at the start of vertical blank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vblnk_prev <= 1'b0;
      r_x_l        <= 12'd0;
      r_y_l        <= 12'd0;
      r_flip_l     <= 1'b0;
    end else begin
      r_vblnk_prev <= vblnk_in;
      if (vblnk_in && !r_vblnk_prev) begin
        r_x_l    <= xpos;
        r_y_l    <= ypos;
        r_flip_l <= flip;
      end
    end
  end

  // Stage 1: ROM address and hit flag; stage 2 waits on the ROM read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pixel_addr  <= 12'h000;
      r_inside_d1 <= 1'b0;
      r_inside_d2 <= 1'b0;
      r_s1        <= '0;
      r_s2        <= '0;
    end else begin
      pixel_addr  <= w_inside ? {w_dy[5:0], w_col[5:0]} : 12'h000;
      r_inside_d1 <= w_inside;
      r_inside_d2 <= r_inside_d1;
      r_s1        <= w_in;
      r_s2        <= r_s1;
    end
  end

  // Stage 3: registered output with the sprite pixel muxed over the background.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s3 <= '0;
    end else begin
      r_s3     <= r_s2;
      r_s3.rgb <= w_rgb_mix;
    end
  end

  assign hcount_out = r_s3.hcount;
  assign vcount_out = r_s3.vcount;
  assign hsync_out  = r_s3.hsync;
  assign vsync_out  = r_s3.vsync;
  assign hblnk_out  = r_s3.hblnk;
  assign vblnk_out  = r_s3.vblnk;
  assign rgb_out    = r_s3.rgb;

endmodule

// File: tb/tb_draw_player_sprite.sv
// Directed bench for draw_player_sprite with a behavioural one-cycle ROM.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
module tb_draw_player_sprite;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [11:0] xpos = '0, ypos = '0;
  logic        flip = 1'b0;
  logic [10:0] hcount_in = '0, vcount_in = '0;
  logic        hsync_in = 1'b0, vsync_in = 1'b0, hblnk_in = 1'b0, vblnk_in = 1'b0;
  logic [11:0] rgb_in = '0;
  logic [11:0] pixel_addr;
  logic [11:0] rgb_pixel = '0;
  logic [10:0] hcount_out, vcount_out;
  logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
  logic [11:0] rgb_out;

  // ROM model: returns its address as colour, or a fixed colour when forced.
  logic        rom_const_en = 1'b0;
  logic [11:0] rom_const = 12'h000;

  int n_tests = 0;
  int n_fail  = 0;

  draw_player_sprite dut (
    .clk(clk), .rst_n(rst_n), .xpos(xpos), .ypos(ypos), .flip(flip),
    .hcount_in(hcount_in), .vcount_in(vcount_in), .hsync_in(hsync_in),
    .vsync_in(vsync_in), .hblnk_in(hblnk_in), .vblnk_in(vblnk_in), .rgb_in(rgb_in),
    .pixel_addr(pixel_addr), .rgb_pixel(rgb_pixel),
    .hcount_out(hcount_out), .vcount_out(vcount_out), .hsync_out(hsync_out),
    .vsync_out(vsync_out), .hblnk_out(hblnk_out), .vblnk_out(vblnk_out), .rgb_out(rgb_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rgb_pixel <= rom_const_en ? rom_const : pixel_addr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Start of vertical blank with the new position present on that same cycle.
  task automatic latch_pos(input logic [11:0] x, input logic [11:0] y, input logic f);
    xpos = x; ypos = y; flip = f;
    hblnk_in = 1'b0; vblnk_in = 1'b1;
    step();
    vblnk_in = 1'b0;
    step();
  endtask

  // Hold one pixel for three edges: address after the first, output after the third.
  task automatic pix(input logic [10:0] h, input logic [10:0] v, input logic hb,
                     input logic [11:0] bg, output logic [11:0] addr, output logic [11:0] rgb);
    hcount_in = h; vcount_in = v; hblnk_in = hb; vblnk_in = 1'b0; rgb_in = bg;
    step();
    addr = pixel_addr;
    step();
    step();
    rgb = rgb_out;
    chk("hcount_out", {21'd0, hcount_out}, {21'd0, h});
  endtask

  logic [11:0] a, c;
  logic        hist [0:15];
  logic [15:0] pat;

  initial begin
    // Asynchronous reset with random inputs, checked before any clock edge.
    hcount_in = 11'($urandom); vcount_in = 11'($urandom); rgb_in = 12'($urandom);
    hsync_in = 1'b1; vsync_in = 1'b1; xpos = 12'($urandom); ypos = 12'($urandom);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_addr", {20'd0, pixel_addr}, 32'h0);
    chk("rst_rgb", {20'd0, rgb_out}, 32'h0);
    chk("rst_hsync", {31'd0, hsync_out}, 32'h0);
    step(); step();
    chk("rst_hcnt", {21'd0, hcount_out}, 32'h0);
    chk("rst_vsync", {31'd0, vsync_out}, 32'h0);

    // Release and check hsync is delayed by exactly three edges.
    pat = 16'b1011_0011_1010_0110;
    vblnk_in = 1'b0; hblnk_in = 1'b0;
    rst_n = 1'b1;
    for (int m = 0; m < 16; m++) begin
      chk("hsync_dly", {31'd0, hsync_out}, (m >= 3) ? {31'd0, hist[m-3]} : 32'h0);
      hist[m] = pat[m];
      hsync_in = hist[m];
      step();
    end
    hsync_in = 1'b0; vsync_in = 1'b0;

    // Placement at (100,50), unflipped.
    latch_pos(12'd100, 12'd50, 1'b0);
    pix(11'd100, 11'd50, 1'b0, 12'h123, a, c);
    chk("place_tl_addr", {20'd0, a}, 32'h000);
    pix(11'd147, 11'd113, 1'b0, 12'h123, a, c);
    chk("place_br_addr", {20'd0, a}, 32'hFEF);
    chk("place_br_rgb", {20'd0, c}, 32'hFEF);
    pix(11'd99, 11'd50, 1'b0, 12'h123, a, c);
    chk("left_out_rgb", {20'd0, c}, 32'h123);
    chk("left_out_addr", {20'd0, a}, 32'h000);
    pix(11'd148, 11'd50, 1'b0, 12'h123, a, c);
    chk("right_out_rgb", {20'd0, c}, 32'h123);
    pix(11'd100, 11'd114, 1'b0, 12'h123, a, c);
    chk("below_out_rgb", {20'd0, c}, 32'h123);

    // Horizontal mirror.
    latch_pos(12'd100, 12'd50, 1'b1);
    pix(11'd100, 11'd50, 1'b0, 12'h123, a, c);
    chk("flip_l_addr", {20'd0, a}, 32'h02F);
    chk("flip_l_rgb", {20'd0, c}, 32'h02F);
    pix(11'd147, 11'd51, 1'b0, 12'h123, a, c);
    chk("flip_r_addr", {20'd0, a}, 32'h040);

    // Transparency and blanking pass-through.
    latch_pos(12'd100, 12'd50, 1'b0);
    rom_const_en = 1'b1; rom_const = 12'hF0F;
    pix(11'd120, 11'd60, 1'b0, 12'h123, a, c);
    chk("key_rgb", {20'd0, c}, 32'h123);
    rom_const = 12'hABC;
    pix(11'd120, 11'd60, 1'b0, 12'h123, a, c);
    chk("opaque_rgb", {20'd0, c}, 32'hABC);
    pix(11'd120, 11'd60, 1'b1, 12'h000, a, c);
    chk("hblank_rgb", {20'd0, c}, 32'h000);
    chk("hblank_addr", {20'd0, a}, 32'h000);
    rom_const_en = 1'b0;

    // Mid-frame position change waits for the next vblank rise.
    xpos = 12'd200;
    pix(11'd101, 11'd50, 1'b0, 12'h123, a, c);
    chk("hold_old_addr", {20'd0, a}, 32'h001);
    chk("hold_old_rgb", {20'd0, c}, 32'h001);
    pix(11'd201, 11'd50, 1'b0, 12'h123, a, c);
    chk("hold_new_rgb", {20'd0, c}, 32'h123);
    latch_pos(12'd200, 12'd50, 1'b0);
    pix(11'd201, 11'd50, 1'b0, 12'h123, a, c);
    chk("moved_new_addr", {20'd0, a}, 32'h001);
    pix(11'd101, 11'd50, 1'b0, 12'h123, a, c);
    chk("moved_old_rgb", {20'd0, c}, 32'h123);

    // Clipping at the right edge: no wrap into columns 0..29.
    latch_pos(12'd2030, 12'd0, 1'b0);
    pix(11'd2030, 11'd0, 1'b0, 12'h123, a, c);
    chk("clip_first_rgb", {20'd0, c}, 32'h000);
    pix(11'd2047, 11'd5, 1'b0, 12'h123, a, c);
    chk("clip_last_addr", {20'd0, a}, 32'h151);
    pix(11'd0, 11'd5, 1'b0, 12'h123, a, c);
    chk("clip_col0_rgb", {20'd0, c}, 32'h123);
    pix(11'd29, 11'd5, 1'b0, 12'h123, a, c);
    chk("clip_col29_rgb", {20'd0, c}, 32'h123);
    chk("clip_col29_addr", {20'd0, a}, 32'h000);

    // Mid-frame reset: latches return to origin, unflipped.
    latch_pos(12'd300, 12'd300, 1'b1);
    hcount_in = 11'd301; vcount_in = 11'd301;
    step();
    rst_n = 1'b0;
    #1;
    chk("midrst_addr", {20'd0, pixel_addr}, 32'h000);
    #1 rst_n = 1'b1;
    step();
    pix(11'd1, 11'd1, 1'b0, 12'h123, a, c);
    chk("midrst_org_addr", {20'd0, a}, 32'h041);
    chk("midrst_org_rgb", {20'd0, c}, 32'h041);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/draw_player_sprite.md
# draw_player_sprite

Overlays the 48x64 player sprite onto the VGA pixel stream at a frame-latched position, optionally mirrored horizontally. Sits directly upstream of `image_rom`: it generates the ROM `address` from the current beam coordinates, receives the ROM's one-cycle-late `rgb`, and muxes it over the background. All VGA timing signals are delayed to stay aligned with the pixel. Key-coloured sprite pixels are transparent.

## Interface
Parameters:
- `IMG_W`, 48, sprite width in pixels (≤ 64)
- `IMG_H`, 64, sprite height in pixels (≤ 64)
- `KEY_RGB`, 12'hF0F, transparent colour; sprite pixels equal to it show the background

Ports:
- `clk`  in  1  pixel clock; one clock, all logic on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `xpos`  in  12  sprite left column, unsigned
- `ypos`  in  12  sprite top row, unsigned
- `flip`  in  1  1 = mirror sprite horizontally (player facing left)
- `hcount_in`, `vcount_in`  in  11 each  beam coordinates
- `hsync_in`, `vsync_in`, `hblnk_in`, `vblnk_in`  in  1 each  timing
- `rgb_in`  in  12  background pixel
- `pixel_addr`  out  12  ROM address = {row[5:0], col[5:0]}
- `rgb_pixel`  in  12  ROM data, valid one cycle after `pixel_addr`
- `hcount_out`, `vcount_out`, `hsync_out`, `vsync_out`, `hblnk_out`, `vblnk_out`, `rgb_out`  out  as inputs  delayed stream

## Operation
- Frame latch: `xpos`, `ypos`, `flip` copied into `x_l`, `y_l`, `flip_l` on the cycle where `vblnk_in`=1 and previous-cycle `vblnk_in`=0 (start of vertical blank). Values held for the whole frame; mid-frame input changes have no visible effect until next vblank. Reset: `x_l`=`y_l`=0, `flip_l`=0.
- Stage 1 (registered): `dx = hcount_in - x_l`, `dy = vcount_in - y_l` (12-bit). `inside = hcount_in ≥ x_l && hcount_in < x_l+IMG_W && vcount_in ≥ y_l && vcount_in < y_l+IMG_H && !hblnk_in && !vblnk_in`; sums `x_l+IMG_W`, `y_l+IMG_H` computed 13-bit, no wrap (sprite partly beyond 2047 is clipped, never wrapped to left/top). `col = flip_l ? IMG_W-1-dx : dx`. `pixel_addr <= inside ? {dy[5:0], col[5:0]} : 12'h000`.
- Stage 2: ROM registers `rgb_pixel`; block delays `inside` and full timing/`rgb_in` bundle one more stage.
- Stage 3 (registered): `rgb_out <= (inside_d2 && rgb_pixel != KEY_RGB) ? rgb_pixel : rgb_in_d2`; timing signals output from third delay stage.
- Blanking: when `hblnk_in` or `vblnk_in` is set the pixel passes through untouched (`rgb_in` forced to 0 by upstream is preserved).

## Timing
- Latency: every output equals the corresponding input 3 clock edges earlier; `pixel_addr` is 1 edge after the driving `hcount_in`/`vcount_in`.
- Reset (`rst_n`=0, asynchronous): all outputs, `pixel_addr`, all pipeline registers and latches = 0 immediately, independent of `clk`. After release, first 3 cycles of output are zeros then the delayed stream.
- Reset mid-frame: latches return to 0; sprite drawn at (0,0) unflipped until the next vblank rising edge loads new values.
- Vblank edge and position change in same cycle: the value present on that cycle is latched.
- No handshake; one pixel per clock, no stalls.

## Test plan
- Reset: hold `rst_n`=0 with random inputs -> all outputs and `pixel_addr` = 0; release, feed stream -> `hsync_out` equals `hsync_in` delayed exactly 3 cycles.
- Placement: latch `xpos`=100, `ypos`=50, `flip`=0; ROM model returns address as colour -> at (hcount,vcount)=(100,50) `pixel_addr`=12'h000, at (147,113) `pixel_addr`=12'hFEF; (99,50) and (148,50) -> `rgb_out`=`rgb_in`.
- Flip: same position, `flip`=1 -> at (100,50) `pixel_addr`=12'h02F (col 47), at (147,50) col 0.
- Transparency: ROM returns 12'hF0F inside sprite, `rgb_in`=12'h123 -> `rgb_out`=12'h123; ROM returns 12'hABC -> `rgb_out`=12'hABC.
- Frame latch: change `xpos` 100->200 mid-frame -> sprite stays at 100 for rest of frame, moves to 200 after next `vblnk_in` rise.
- Clipping: `xpos`=2030 -> columns 2030..2047 drawn, no sprite pixels at hcount 0..29.
